// File: rtl/axi_lite_pkg.sv
// Purpose: shared encodings for the AXI4-Lite memory port arbiter (response codes, FSM states, GRANT values).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] GRANT_IDLE  = 2'b00;
    localparam logic [1:0] GRANT_WR    = 2'b01;
    localparam logic [1:0] GRANT_RD    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Which path was serviced most recently; drives the round-robin tie break.
    typedef enum logic {
        LG_WRITE = 1'b0,
        LG_READ  = 1'b1
    } last_grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose: two-requester round-robin picker (write vs read), purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the caller only samples grant_oh while it is idle.
// Ports: eligible_w/eligible_r requests, last_grant history, grant_oh one-hot ([0] write, [1] read).
module rr_arbiter2
    import axi_lite_pkg::*;
(
    input  logic        eligible_w,
    input  logic        eligible_r,
    input  last_grant_e last_grant,
    output logic [1:0]  grant_oh
);

    always_comb begin
        grant_oh = 2'b00;
        if (eligible_w && eligible_r) begin
            // On a tie, the path that did not go last wins.
            grant_oh = (last_grant == LG_READ) ? 2'b01 : 2'b10;
        end else if (eligible_w) begin
            grant_oh = 2'b01;
        end else if (eligible_r) begin
            grant_oh = 2'b10;
        end
    end

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Purpose: shares one single-port memory between the AXI4-Lite write and read paths, one access at a time.
// Latency: request sampled in IDLE -> MEM_EN next cycle -> response strobe the cycle after MEM_ACK (2 cycles zero-wait).
// Backpressure: requests are level and held until their response strobe; the memory stalls via MEM_ACK.
// Ports: W* write request/response, R* read request/response, MEM_* memory command/ack, GRANT owner status.
// Optional: define ARB_TIMEOUT_EN to abort an access with SLVERR after TIMEOUT_CYCLES cycles without MEM_ACK.
module axi_mem_port_arbiter
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_DEPTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int RESP_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    output logic [RESP_WIDTH-1:0] WRESP,
    output logic                  WRESPREADY,
    input  logic                  REN,
    input  logic [ADDR_WIDTH-1:0] RADDR,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [RESP_WIDTH-1:0] RRESP,
    output logic                  RRESPREADY,
    output logic                  MEM_EN,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic [STRB_WIDTH-1:0] MEM_WSTRB,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    input  logic                  MEM_ACK,
    input  logic                  MEM_ERR,
    output logic [1:0]            GRANT
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (ADDR_WIDTH >= 32) begin : g_bad_addr
        $error("ADDR_WIDTH must be below 32");
    end

    arb_state_e            state_q, state_d;
    last_grant_e           last_grant_q, last_grant_d;
    logic                  wr_mask_q, wr_mask_d;
    logic                  rd_mask_q, rd_mask_d;
    logic [1:0]            grant_q, grant_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [RESP_WIDTH-1:0] wresp_q, wresp_d;
    logic                  wrespready_q, wrespready_d;
    logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
    logic                  rrespready_q, rrespready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    logic                  eligible_w, eligible_r;
    logic [1:0]            pick_oh;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_addr_ext;
    logic                  fin;
    logic [RESP_WIDTH-1:0] fin_code;
    logic [DATA_WIDTH-1:0] fin_rdata;

    // A served request stays masked until it is seen low, so a held level is never serviced twice.
    assign eligible_w = WEN & ~wr_mask_q;
    assign eligible_r = REN & ~rd_mask_q;

    rr_arbiter2 u_rr (
        .eligible_w (eligible_w),
        .eligible_r (eligible_r),
        .last_grant (last_grant_q),
        .grant_oh   (pick_oh)
    );

    assign sel_addr     = pick_oh[0] ? WADDR : RADDR;
    assign sel_addr_ext = 32'(sel_addr);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_mask_d    = wr_mask_q;
        rd_mask_d    = rd_mask_q;
        grant_d      = grant_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        wresp_d      = wresp_q;
        wrespready_d = 1'b0;
        rresp_d      = rresp_q;
        rrespready_d = 1'b0;
        rdata_d      = rdata_q;
        fin          = 1'b0;
        fin_code     = RESP_WIDTH'(RESP_OKAY);
        fin_rdata    = MEM_RDATA;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d     = '0;
`endif

        if (!WEN) wr_mask_d = 1'b0;
        if (!REN) rd_mask_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|pick_oh) begin
                    grant_d     = pick_oh[0] ? GRANT_WR : GRANT_RD;
                    mem_we_d    = pick_oh[0];
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = WDATA;
                    mem_wstrb_d = WSTRB;
                    if (sel_addr_ext >= 32'(DATA_DEPTH)) begin
                        // Out-of-range address never reaches the memory.
                        fin       = 1'b1;
                        fin_code  = RESP_WIDTH'(RESP_DECERR);
                        fin_rdata = '0;
                    end else begin
                        state_d  = ST_ACCESS;
                        mem_en_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (MEM_ACK) begin
                    fin      = 1'b1;
                    fin_code = MEM_ERR ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
`ifdef ARB_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    fin       = 1'b1;
                    fin_code  = RESP_WIDTH'(RESP_SLVERR);
                    fin_rdata = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = GRANT_IDLE;
                // Mask set overrides the clear above.
                if (grant_q == GRANT_WR) begin
                    last_grant_d = LG_WRITE;
                    wr_mask_d    = 1'b1;
                end else begin
                    last_grant_d = LG_READ;
                    rd_mask_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Common completion: response registered so the strobe appears in the RESP cycle.
        if (fin) begin
            state_d  = ST_RESP;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
            if (grant_d == GRANT_WR) begin
                wrespready_d = 1'b1;
                wresp_d      = fin_code;
            end else begin
                rrespready_d = 1'b1;
                rresp_d      = fin_code;
                rdata_d      = fin_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LG_READ;
            wr_mask_q    <= 1'b0;
            rd_mask_q    <= 1'b0;
            grant_q      <= GRANT_IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            wresp_q      <= '0;
            wrespready_q <= 1'b0;
            rresp_q      <= '0;
            rrespready_q <= 1'b0;
            rdata_q      <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_mask_q    <= wr_mask_d;
            rd_mask_q    <= rd_mask_d;
            grant_q      <= grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            wresp_q      <= wresp_d;
            wrespready_q <= wrespready_d;
            rresp_q      <= rresp_d;
            rrespready_q <= rrespready_d;
            rdata_q      <= rdata_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign WRESP      = wresp_q;
    assign WRESPREADY = wrespready_q;
    assign RRESP      = rresp_q;
    assign RRESPREADY = rrespready_q;
    assign RDATA      = rdata_q;
    assign MEM_EN     = mem_en_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign MEM_WSTRB  = mem_wstrb_q;
    assign GRANT      = grant_q;

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Purpose: directed scoreboard bench for axi_mem_port_arbiter (DATA_DEPTH = 16).
// Latency: expected strobe cycles are carried in the scoreboard entries.
// Backpressure: a bench-side memory responder acks after a programmable number of MEM_EN cycles.
module tb_axi_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        WEN, REN;
    logic [4:0]  WADDR, RADDR;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  WRESP, RRESP;
    logic        WRESPREADY, RRESPREADY;
    logic [31:0] RDATA;
    logic        MEM_EN, MEM_WE;
    logic [4:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK, MEM_ERR;
    logic [1:0]  GRANT;

    axi_mem_port_arbiter #(
        .DATA_WIDTH(32), .DATA_DEPTH(16), .ADDR_WIDTH(5),
        .STRB_WIDTH(4), .RESP_WIDTH(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(rst_n),
        .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .WSTRB(WSTRB),
        .WRESP(WRESP), .WRESPREADY(WRESPREADY),
        .REN(REN), .RADDR(RADDR), .RDATA(RDATA), .RRESP(RRESP), .RRESPREADY(RRESPREADY),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_WSTRB(MEM_WSTRB), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MEM_ERR(MEM_ERR),
        .GRANT(GRANT)
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_acc = 0;
    int rd_acc = 0;
    int en_cyc = 0;
    int ack_wait = 0;
    bit ack_never = 0;
    logic [31:0] rd_val = '0;
    logic        err_val = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [1:0] r, input logic [31:0] d, input int c);
        exp_t e;
        e.resp = r;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory model: acks once MEM_EN has been high for ack_wait+1 cycles.
    always @(negedge clk) begin
        if (MEM_EN) begin
            if (en_cyc == 0) begin
                if (MEM_WE) wr_acc++;
                else        rd_acc++;
            end
            if (!ack_never && en_cyc == ack_wait) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = rd_val;
                MEM_ERR   = err_val;
            end else begin
                MEM_ACK = 1'b0;
            end
            en_cyc++;
        end else begin
            MEM_ACK = 1'b0;
            MEM_ERR = 1'b0;
            en_cyc  = 0;
        end
    end

    // Response monitor: every strobe must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (WRESPREADY) begin
                if (wq.size() == 0) begin
                    check("wstrobe_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = wq.pop_front();
                    check("wresp_code", WRESP, e.resp);
                    check("wresp_cycle", cyc, e.cyc);
                end
            end
            if (RRESPREADY) begin
                if (rq.size() == 0) begin
                    check("rstrobe_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    check("rresp_code", RRESP, e.resp);
                    check("rresp_data", RDATA, e.data);
                    check("rresp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int w0;
        rst_n = 1'b0; WEN = 1'b0; REN = 1'b0; WADDR = '0; RADDR = '0;
        WDATA = '0; WSTRB = '0; MEM_RDATA = '0; MEM_ACK = 1'b0; MEM_ERR = 1'b0;
        tick(3);
        check("rst_mem_en", MEM_EN, 0);
        check("rst_mem_we", MEM_WE, 0);
        check("rst_grant", GRANT, 0);
        check("rst_wrespready", WRESPREADY, 0);
        check("rst_rrespready", RRESPREADY, 0);
        check("rst_resp", {WRESP, RRESP}, 0);
        check("rst_rdata", RDATA, 0);
        rst_n = 1'b1;
        tick(2);

        // Simultaneous requests after reset: write first, read 3 cycles later.
        WEN = 1; WADDR = 5'd2; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
        REN = 1; RADDR = 5'd5; rd_val = 32'h0BADF00D; err_val = 0; ack_wait = 0;
        c = cyc;
        wq.push_back(mk(2'b00, '0, c + 2));
        rq.push_back(mk(2'b00, 32'h0BADF00D, c + 5));
        tick(1);
        check("sim_grant1", GRANT, 2'b01);
        check("sim_cmd_w", {MEM_EN, MEM_WE, 3'b0, MEM_ADDR}, {1'b1, 1'b1, 3'b0, 5'd2});
        check("sim_wdata", MEM_WDATA, 32'hA5A5A5A5);
        tick(1);
        check("sim_grant_resp", GRANT, 2'b01);
        WEN = 0;
        tick(1);
        check("sim_grant_idle", GRANT, 2'b00);
        tick(1);
        check("sim_grant2", GRANT, 2'b10);
        check("sim_cmd_r", {MEM_EN, MEM_WE, 3'b0, MEM_ADDR}, {1'b1, 1'b0, 3'b0, 5'd5});
        tick(1);
        REN = 0;
        tick(2);
        #1;
        check("sim_acc", {wr_acc[15:0], rd_acc[15:0]}, {16'd1, 16'd1});

        // Zero-wait write, then hold WEN: exactly one access until it is dropped.
        WEN = 1; WADDR = 5'd3; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        c = cyc; w0 = wr_acc;
        wq.push_back(mk(2'b00, '0, c + 2));
        tick(1);
        check("wr_cmd", {MEM_EN, MEM_WE, 3'b0, MEM_ADDR}, {1'b1, 1'b1, 3'b0, 5'd3});
        check("wr_wdata", MEM_WDATA, 32'hDEADBEEF);
        check("wr_wstrb", MEM_WSTRB, 4'hF);
        tick(1);
        check("wr_en_drop", MEM_EN, 0);
        tick(4);
        #1;
        check("held_single", wr_acc - w0, 1);
        WEN = 0;
        tick(2);
        WEN = 1; WDATA = 32'h11223344; WSTRB = 4'h3;
        c = cyc;
        wq.push_back(mk(2'b00, '0, c + 2));
        tick(1);
        check("wr2_wstrb", MEM_WSTRB, 4'h3);
        tick(1);
        WEN = 0;
        tick(2);
        #1;
        check("rereq_second", wr_acc - w0, 2);

        // Read with 4 wait cycles and an error.
        REN = 1; RADDR = 5'd7; ack_wait = 4; rd_val = 32'h12345678; err_val = 1;
        c = cyc;
        rq.push_back(mk(2'b10, 32'h12345678, c + 6));
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("rd_wait_cmd", {GRANT, MEM_EN, MEM_WE, 3'b0, MEM_ADDR}, {2'b10, 1'b1, 1'b0, 3'b0, 5'd7});
        end
        tick(1);
        check("rd_en_drop", MEM_EN, 0);
        REN = 0; ack_wait = 0; err_val = 0;
        tick(2);
        check("rd_hold", {RRESP, RDATA}, {2'b10, 32'h12345678});

        // Illegal address: DECERR without touching the memory.
        w0 = wr_acc;
        WEN = 1; WADDR = 5'd20;
        c = cyc;
        wq.push_back(mk(2'b11, '0, c + 1));
        tick(1);
        check("ill_no_en", MEM_EN, 0);
        check("ill_grant", GRANT, 2'b01);
        WEN = 0;
        tick(3);
        #1;
        check("ill_no_acc", wr_acc - w0, 0);

        // Tie after a write: read wins this time.
        WEN = 1; WADDR = 5'd9; WDATA = 32'hCAFE0001; WSTRB = 4'hF;
        REN = 1; RADDR = 5'd10; rd_val = 32'h55AA55AA;
        c = cyc;
        rq.push_back(mk(2'b00, 32'h55AA55AA, c + 2));
        wq.push_back(mk(2'b00, '0, c + 5));
        tick(1);
        check("tie2_grant", GRANT, 2'b10);
        tick(1);
        REN = 0;
        tick(2);
        check("tie2_grant_w", GRANT, 2'b01);
        tick(1);
        WEN = 0;
        tick(3);

`ifdef ARB_TIMEOUT_EN
        // Memory never acks: abort after 16 MEM_EN cycles with SLVERR and zero data.
        REN = 1; RADDR = 5'd4; ack_never = 1;
        c = cyc;
        rq.push_back(mk(2'b10, 32'h0, c + 17));
        tick(16);
        check("to_en_last", MEM_EN, 1);
        tick(1);
        check("to_en_drop", MEM_EN, 0);
        REN = 0; ack_never = 0;
        tick(3);
`endif

        // Reset in the middle of an access: MEM_EN drops at once, no strobe afterwards.
        REN = 1; RADDR = 5'd6; ack_never = 1;
        tick(2);
        check("mid_en", MEM_EN, 1);
        rst_n = 0;
        #1;
        check("mid_rst_en", MEM_EN, 0);
        check("mid_rst_grant", GRANT, 0);
        REN = 0;
        tick(2);
        rst_n = 1;
        ack_never = 0;
        tick(6);

        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_port_arbiter.md
Name: axi_mem_port_arbiter

Overview:
Shares one single-port register memory between the AXI4-Lite slave write path and read path. The write path presents a level write request with address, data and strobe. The read path presents a level read request with address. The block arbitrates round-robin, sequences one memory access at a time, and returns a one-cycle response strobe plus a 2-bit response code to the winning path. It sits between the write/read channel wrappers and the memory array.

Parameters:
DATA_WIDTH, 32, data bus width
DATA_DEPTH, 64, number of memory words; addresses >= DATA_DEPTH are illegal
ADDR_WIDTH, 5, word address width
STRB_WIDTH, 4, DATA_WIDTH/8 byte strobes
RESP_WIDTH, 2, AXI response width
TIMEOUT_CYCLES, 16, memory ack timeout; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  global clock
reset  in  1  asynchronous, active-low reset
WEN  in  1  write request; level, held until WRESPREADY
WADDR  in  ADDR_WIDTH  write word address
WDATA  in  DATA_WIDTH  write data
WSTRB  in  STRB_WIDTH  byte strobes
WRESP  out  RESP_WIDTH  write response code
WRESPREADY  out  1  one-cycle write-complete strobe
REN  in  1  read request; level, held until RRESPREADY
RADDR  in  ADDR_WIDTH  read word address
RDATA  out  DATA_WIDTH  read data; valid with RRESPREADY
RRESP  out  RESP_WIDTH  read response code
RRESPREADY  out  1  one-cycle read-complete strobe
MEM_EN  out  1  memory access enable
MEM_WE  out  1  1 = write, 0 = read
MEM_ADDR  out  ADDR_WIDTH  memory address
MEM_WDATA  out  DATA_WIDTH  memory write data
MEM_WSTRB  out  STRB_WIDTH  memory byte strobes
MEM_RDATA  in  DATA_WIDTH  memory read data; valid with MEM_ACK
MEM_ACK  in  1  access complete; may assert in the first MEM_EN cycle
MEM_ERR  in  1  access error; sampled with MEM_ACK
GRANT  out  2  status: 01 = write owns port, 10 = read owns port, 00 = idle

Behaviour:
- All outputs are registered.
- Reset (reset low, asynchronous): state IDLE, every output 0, last_grant = READ, wr_mask = 0, rd_mask = 0.
- Reset mid-access: MEM_EN drops immediately, no response is issued, and the requester must re-request.
- Eligibility: eligible_w = WEN & ~wr_mask; eligible_r = REN & ~rd_mask.
- Arbitration in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the one opposite to last_grant, so write wins the first tie after reset.
  - Latch address, data and strobe into registers at grant.
- States: IDLE, ACCESS, RESP.
- IDLE -> RESP (no memory access): granted address >= DATA_DEPTH. Response is DECERR 2'b11.
- IDLE -> ACCESS: legal address. Drive MEM_EN = 1, MEM_WE per grant, and the latched MEM_ADDR/WDATA/WSTRB.
- ACCESS: hold the command stable until MEM_ACK = 1, then go to RESP. Latch MEM_RDATA. Code = MEM_ERR ? SLVERR 2'b10 : OKAY 2'b00. MEM_EN drops the cycle after the ack.
- RESP: pulse WRESPREADY or RRESPREADY for exactly one cycle with WRESP/RRESP (and RDATA for reads). Update last_grant. Set the granted path's mask. Return to IDLE.
- Mask clear: a mask clears in any cycle its request is observed low. Set in RESP has priority over clear. This guarantees a held request is never serviced twice.
- Latency, request to strobe, zero-wait memory:
  - Request sampled in IDLE at cycle 0.
  - MEM_EN in cycle 1, MEM_ACK in cycle 1.
  - Strobe in cycle 2.
  - Back-to-back alternate grants: one access per 3 cycles.
- WRESP/RRESP/RDATA hold their last value between strobes.
- GRANT is nonzero from ACCESS entry through RESP.

Optional Feature:
- Macro ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in ACCESS.
  - If MEM_ACK is absent for TIMEOUT_CYCLES cycles, abort: drop MEM_EN, go to RESP with SLVERR 2'b10, RDATA = 0.
  - The counter clears on leaving ACCESS.
- Macro not defined: ACCESS waits for MEM_ACK indefinitely and no counter exists.

Decomposition:
- Shared package axi_lite_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
  - state encoding ST_IDLE / ST_ACCESS / ST_RESP
  - GRANT encodings
- One sub-module is natural: rr_arbiter2, a two-requester round-robin picker (inputs eligible_w, eligible_r, last_grant; one-hot grant output, purely combinational). The FSM, masks and datapath registers stay in the top.

Test Plan:
- Write, zero-wait memory: WEN = 1, WADDR = 3, WDATA = 0xDEADBEEF, WSTRB = 0xF, MEM_ACK in the first MEM_EN cycle -> MEM_EN/MEM_WE high in cycle 1 with MEM_ADDR = 3; WRESPREADY one-cycle pulse in cycle 2 with WRESP = 00.
- Held request, no double service: WEN held 4 cycles after the strobe -> exactly one MEM_EN/MEM_WE pulse; drop and re-raise WEN -> a second access occurs.
- Simultaneous requests: WEN = REN = 1 from reset -> write granted first, then read; RRESPREADY 3 cycles after WRESPREADY; GRANT sequence 01 then 10.
- Read with wait states and error: REN = 1, RADDR = 7, MEM_ACK after 4 cycles with MEM_RDATA = 0x12345678 and MEM_ERR = 1 -> command held stable 4 cycles; RRESPREADY pulse with RDATA = 0x12345678 and RRESP = 10.
- Illegal address: DATA_DEPTH = 16, WADDR = 20 -> no MEM_EN; WRESPREADY pulse in cycle 1 with WRESP = 11.
- Timeout (ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16) plus reset: MEM_ACK never asserted -> MEM_EN drops and RRESPREADY pulses with RRESP = 10. A separate run asserts reset low mid-ACCESS -> MEM_EN low immediately; no strobe after reset release.
